// File: rtl/stopwatch_pkg.sv
// Shared stopwatch display definitions: scan FSM states and active-high
// 7-segment glyphs ordered {g,f,e,d,c,b,a}.
package stopwatch_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

  localparam logic [6:0] SEG_OFF = 7'b0000000;
  localparam logic [6:0] SEG_0   = 7'b0111111;
  localparam logic [6:0] SEG_1   = 7'b0000110;
  localparam logic [6:0] SEG_2   = 7'b1011011;
  localparam logic [6:0] SEG_3   = 7'b1001111;
  localparam logic [6:0] SEG_4   = 7'b1100110;
  localparam logic [6:0] SEG_5   = 7'b1101101;
  localparam logic [6:0] SEG_6   = 7'b1111101;
  localparam logic [6:0] SEG_7   = 7'b0000111;
  localparam logic [6:0] SEG_8   = 7'b1111111;
  localparam logic [6:0] SEG_9   = 7'b1101111;
  localparam logic [6:0] SEG_A   = 7'b1110111;
  localparam logic [6:0] SEG_B   = 7'b1111100;
  localparam logic [6:0] SEG_C   = 7'b0111001;
  localparam logic [6:0] SEG_D   = 7'b1011110;
  localparam logic [6:0] SEG_E   = 7'b1111001;
  localparam logic [6:0] SEG_F   = 7'b1110001;

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex digit to active-high 7-segment glyph ({g..a}).
module seg7_decode
  import stopwatch_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = SEG_OFF;
    case (digit)
      4'h0: glyph = SEG_0;
      4'h1: glyph = SEG_1;
      4'h2: glyph = SEG_2;
      4'h3: glyph = SEG_3;
      4'h4: glyph = SEG_4;
      4'h5: glyph = SEG_5;
      4'h6: glyph = SEG_6;
      4'h7: glyph = SEG_7;
      4'h8: glyph = SEG_8;
      4'h9: glyph = SEG_9;
      4'hA: glyph = SEG_A;
      4'hB: glyph = SEG_B;
      4'hC: glyph = SEG_C;
      4'hD: glyph = SEG_D;
      4'hE: glyph = SEG_E;
      4'hF: glyph = SEG_F;
      default: glyph = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/display_scanner.sv
// Multiplexed 7-segment scanner: one digit per refresh tick, with an all-off
// dead time between digits and per-slot snapshot of the digit being shown.
module display_scanner
  import stopwatch_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int BLANK_CYCLES = 16,
  parameter bit ACTIVE_LOW   = 1'b1,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lead_zero,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    overrun
);

  localparam int CNT_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{ACTIVE_LOW}};
  localparam logic [6:0]            SEG_LVL  = {7{ACTIVE_LOW}};

  scan_state_e           state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  overrun_q, overrun_d;
  logic [3:0]            slot_digit_q, slot_digit_d;
  logic                  slot_dp_q, slot_dp_d;
  logic                  slot_blank_q, slot_blank_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;

  logic                  enter_show;
  logic                  upper_zero;
  logic [6:0]            glyph;
  logic [NUM_DIGITS-1:0] an_on;
  logic [6:0]            seg_on;
  logic                  dp_on;

  seg7_decode u_decode (
    .digit (slot_digit_d),
    .glyph (glyph)
  );

  // Slot values are captured only when a slot starts, so mid-slot input changes never tear.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    overrun_d    = overrun_q;
    slot_digit_d = slot_digit_q;
    slot_dp_d    = slot_dp_q;
    slot_blank_d = slot_blank_q;
    enter_show   = 1'b0;
    upper_zero   = 1'b1;

    case (state_q)
      ST_BLANK: begin
        if (tick) overrun_d = 1'b1;
        if (cnt_q > CNT_W'(1)) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          cnt_d      = '0;
          state_d    = ST_SHOW;
          enter_show = 1'b1;
        end
      end
      ST_SHOW: begin
        if (tick) begin
          idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
          if (BLANK_CYCLES == 0) begin
            enter_show = 1'b1;
          end else begin
            state_d = ST_BLANK;
            cnt_d   = CNT_W'(BLANK_CYCLES);
          end
        end
      end
      default: state_d = ST_BLANK;
    endcase

    for (int j = 0; j < NUM_DIGITS; j++) begin
      if ((j >= int'(idx_d)) && (digits_in[4*j +: 4] != 4'h0)) upper_zero = 1'b0;
    end

    if (enter_show) begin
      slot_digit_d = digits_in[4*int'(idx_d) +: 4];
      slot_dp_d    = dp_in[idx_d];
      slot_blank_d = blank_lead_zero && (idx_d != '0) && upper_zero;
    end
  end

  // Pin levels are computed from next-cycle state so the outputs themselves are flops.
  always_comb begin
    an_on  = '0;
    seg_on = SEG_OFF;
    dp_on  = 1'b0;
    if (state_d == ST_SHOW) begin
      an_on[idx_d] = 1'b1;
      if (!slot_blank_d) seg_on = glyph;
      dp_on = slot_dp_d;
    end
    an_d  = an_on ^ AN_OFF;
    seg_d = seg_on ^ SEG_LVL;
    dp_d  = dp_on ^ ACTIVE_LOW;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_BLANK;
      idx_q        <= '0;
      cnt_q        <= CNT_W'(BLANK_CYCLES);
      overrun_q    <= 1'b0;
      slot_digit_q <= 4'h0;
      slot_dp_q    <= 1'b0;
      slot_blank_q <= 1'b0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_LVL;
      dp_q         <= ACTIVE_LOW;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      overrun_q    <= overrun_d;
      slot_digit_q <= slot_digit_d;
      slot_dp_q    <= slot_dp_d;
      slot_blank_q <= slot_blank_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign an_out    = an_q;
  assign seg_out   = seg_q;
  assign dp_out    = dp_q;
  assign digit_idx = idx_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_display_scanner.sv
// Scoreboard bench for display_scanner: default build checked slot by slot
// against a glyph-table model, plus a direct-swap active-high build.
module tb_display_scanner;

  localparam int ND = 4;
  localparam int BC = 16;

  typedef struct {
    int         idx;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    int         off;
  } slot_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic [15:0] digits = 16'h1234;
  logic [3:0]  dp = 4'b0000;
  logic        blz = 1'b0;
  logic [3:0]  an_out;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [1:0]  digit_idx;
  logic        overrun;

  logic        rst2 = 1'b1;
  logic        tick2 = 1'b0;
  logic [15:0] digits2 = 16'h80C8;
  logic [3:0]  dp2 = 4'b0101;
  logic        blz2 = 1'b0;
  logic [3:0]  an2;
  logic [6:0]  seg2;
  logic        dp2_out;
  logic [1:0]  idx2;
  logic        overrun2;

  int    total = 0;
  int    bad = 0;
  slot_t sb_q[$];
  int    model_idx = 0;
  logic  exp_overrun = 1'b0;

  string seg_names[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                           "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  always #5 clk = ~clk;

  display_scanner #(.NUM_DIGITS(ND), .BLANK_CYCLES(BC), .ACTIVE_LOW(1'b1)) dut (
    .clk             (clk),
    .rst             (rst),
    .tick            (tick),
    .digits_in       (digits),
    .dp_in           (dp),
    .blank_lead_zero (blz),
    .an_out          (an_out),
    .seg_out         (seg_out),
    .dp_out          (dp_out),
    .digit_idx       (digit_idx),
    .overrun         (overrun)
  );

  display_scanner #(.NUM_DIGITS(ND), .BLANK_CYCLES(0), .ACTIVE_LOW(1'b0)) dut_swap (
    .clk             (clk),
    .rst             (rst2),
    .tick            (tick2),
    .digits_in       (digits2),
    .dp_in           (dp2),
    .blank_lead_zero (blz2),
    .an_out          (an2),
    .seg_out         (seg2),
    .dp_out          (dp2_out),
    .digit_idx       (idx2),
    .overrun         (overrun2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph_of(input int v);
    logic [6:0] g;
    int b;
    g = 7'b0;
    for (int k = 0; k < seg_names[v].len(); k++) begin
      b = int'(seg_names[v][k]) - 97;
      g[b] = 1'b1;
    end
    return g;
  endfunction

  // Expected pins for a slot showing digit i, derived from the leading-zero rule and glyph table.
  function automatic slot_t model_slot(input int i, input logic [15:0] d, input logic [3:0] dpv,
                                       input logic bl, input bit al, input int off);
    slot_t s;
    int    v;
    bit    blanked;
    v       = int'((d >> (4*i)) & 16'hF);
    blanked = bl && (i > 0) && ((d >> (4*i)) == 16'h0);
    s.idx   = i;
    s.an    = 4'(1 << i);
    s.seg   = blanked ? 7'b0 : glyph_of(v);
    s.dp    = dpv[i];
    s.off   = off;
    if (al) begin
      s.an  = ~s.an;
      s.seg = ~s.seg;
      s.dp  = ~s.dp;
    end
    return s;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  // Called right after a slot begins its dead time; ends with the tick that starts the next slot.
  task automatic run_slot(input logic [15:0] nd, input logic [3:0] ndp, input logic nblz, input bit ovr);
    if (ovr) begin
      wait_cycles(3);
      pulse_tick();
      exp_overrun = 1'b1;
      wait_cycles(BC + 2 - 4);
    end else begin
      wait_cycles(BC + 2);
    end
    digits = nd;
    dp     = ndp;
    blz    = nblz;
    wait_cycles($urandom_range(1, 20));
    model_idx = (model_idx + 1) % ND;
    sb_q.push_back(model_slot(model_idx, digits, dp, blz, 1'b1, BC));
    pulse_tick();
  endtask

  function automatic logic [15:0] rand_digits();
    logic [15:0] d;
    d = 16'($urandom);
    case ($urandom_range(0, 3))
      0: d = d & 16'h000F;
      1: d = d & 16'h00FF;
      2: d = d & 16'h0FFF;
      default: d = d;
    endcase
    return d;
  endfunction

  // Monitor: every lit slot is popped from the scoreboard and held against it until it ends.
  initial begin
    slot_t cur;
    bit    in_slot;
    int    off_cnt;
    in_slot = 1'b0;
    off_cnt = 0;
    cur = '{idx: 0, an: 4'hF, seg: 7'h7F, dp: 1'b1, off: 0};
    forever begin
      @(negedge clk);
      if (rst) begin
        in_slot = 1'b0;
        off_cnt = 0;
      end else begin
        check("overrun", 32'(overrun), 32'(exp_overrun));
        if (an_out == 4'hF) begin
          check("off_levels", {24'h0, seg_out, dp_out}, 32'hFF);
          off_cnt++;
          in_slot = 1'b0;
        end else if (!in_slot || an_out != cur.an) begin
          if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_slot actual an=%b required=no slot at %0t", an_out, $time);
            cur.an  = an_out;
            cur.seg = seg_out;
            cur.dp  = dp_out;
          end else begin
            cur = sb_q.pop_front();
            check("slot_an", 32'(an_out), 32'(cur.an));
            check("slot_seg", 32'(seg_out), 32'(cur.seg));
            check("slot_dp", 32'(dp_out), 32'(cur.dp));
            check("slot_idx", 32'(digit_idx), 32'(cur.idx));
            check("dead_cycles", 32'(off_cnt), 32'(cur.off));
          end
          in_slot = 1'b1;
          off_cnt = 0;
        end else begin
          check("hold_seg", 32'(seg_out), 32'(cur.seg));
          check("hold_dp", 32'(dp_out), 32'(cur.dp));
        end
      end
    end
  end

  initial begin
    slot_t e;
    int    ovr_at;
    wait_cycles(3);
    check("rst_an", 32'(an_out), 32'hF);
    check("rst_seg", 32'(seg_out), 32'h7F);
    check("rst_dp", 32'(dp_out), 32'h1);
    check("rst_idx", 32'(digit_idx), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst2_an", 32'(an2), 32'h0);
    check("rst2_seg", 32'(seg2), 32'h0);
    check("rst2_dp", 32'(dp2_out), 32'h0);

    rst       = 1'b0;
    model_idx = 0;
    sb_q.push_back(model_slot(0, digits, dp, blz, 1'b1, BC));

    for (int s = 0; s < 4; s++) run_slot(16'h1234, 4'b0000, 1'b0, 1'b0);
    for (int s = 0; s < 4; s++) run_slot(16'h0005, 4'b0000, 1'b1, 1'b0);
    for (int s = 0; s < 4; s++) run_slot(16'h0005, 4'b0000, 1'b0, 1'b0);
    for (int s = 0; s < 4; s++) run_slot(16'h0000, 4'b0000, 1'b1, 1'b0);

    ovr_at = 3;
    for (int s = 0; s < 24; s++) begin
      run_slot(rand_digits(), 4'($urandom), 1'($urandom), (s == ovr_at) || ($urandom_range(0, 7) == 0));
    end

    for (int s = 0; s < ND; s++) begin
      if (model_idx == 2) break;
      run_slot(rand_digits(), 4'($urandom), 1'($urandom), 1'b0);
    end
    check("reach_digit2", 32'(model_idx), 32'd2);
    wait_cycles(BC + 2);
    check("pre_reset_queue", 32'(sb_q.size()), 32'd0);

    rst = 1'b1;
    #1;
    check("midrst_an", 32'(an_out), 32'hF);
    check("midrst_seg", 32'(seg_out), 32'h7F);
    check("midrst_dp", 32'(dp_out), 32'h1);
    check("midrst_idx", 32'(digit_idx), 32'h0);
    check("midrst_overrun", 32'(overrun), 32'h0);
    exp_overrun = 1'b0;
    wait_cycles(2);
    rst       = 1'b0;
    model_idx = 0;
    sb_q.push_back(model_slot(0, digits, dp, blz, 1'b1, BC));
    wait_cycles(BC + 6);
    check("final_queue", 32'(sb_q.size()), 32'd0);

    rst2 = 1'b0;
    wait_cycles(3);
    for (int k = 0; k < 6; k++) begin
      e = model_slot(k % ND, digits2, dp2, blz2, 1'b0, 0);
      #2;
      check("swap_an", 32'(an2), 32'(e.an));
      check("swap_seg", 32'(seg2), 32'(e.seg));
      check("swap_dp", 32'(dp2_out), 32'(e.dp));
      check("swap_idx", 32'(idx2), 32'(k % ND));
      tick2 = 1'b1;
      @(posedge clk);
      #1;
      tick2 = 1'b0;
    end
    e = model_slot(6 % ND, digits2, dp2, blz2, 1'b0, 0);
    #2;
    check("swap_an_last", 32'(an2), 32'(e.an));
    check("swap_overrun", 32'(overrun2), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
